// File: rtl/vector_lane_serializer_if.sv
// rtl/vector_lane_serializer_if.sv - per-lane output beat channel (valid/ready with data, index, last)
interface vector_lane_serializer_if #(
    parameter int DW   = 32,
    parameter int IDXW = 4
);
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [IDXW-1:0] out_idx;
    logic            out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/vector_lane_serializer.sv
// rtl/vector_lane_serializer.sv - captures a LANES x DW vector and streams it one lane per handshake (optional VSER_MASK_EN lane mask)
module vector_lane_serializer #(
    parameter int LANES = 16,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LANES*DW-1:0]   vec_in,
`ifdef VSER_MASK_EN
    input  logic [LANES-1:0]      lane_mask,
`endif
    output logic                  busy,
    output logic                  done,
    vector_lane_serializer_if.master out_if
);

    localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [LANES*DW-1:0]   vec_q, vec_d;
    // Lanes still to be emitted after the beat currently on the output.
    logic [LANES-1:0]      rem_q, rem_d;
    logic                  valid_q, valid_d;
    logic [DW-1:0]         data_q, data_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;

    logic [LANES-1:0]      start_mask;

`ifdef VSER_MASK_EN
    assign start_mask = lane_mask;
`else
    assign start_mask = '1;
`endif

    // Lowest enabled lane search. In IDLE it looks at the incoming vector and
    // mask so the first beat is ready one edge after start; in STREAM it looks
    // at the captured vector and the remaining-lane mask.
    logic [LANES-1:0]      pe_mask;
    logic [LANES-1:0]      pe_rest;
    logic [LANES*DW-1:0]   pe_vec;
    logic                  pe_any;
    logic [IDXW-1:0]       pe_idx;
    logic [DW-1:0]         pe_data;

    // Priority encode the selected mask, fetch the lane, and strip it from the mask.
    always_comb begin
        pe_mask = (state_q == IDLE) ? start_mask : rem_q;
        pe_vec  = (state_q == IDLE) ? vec_in : vec_q;
        pe_any  = 1'b0;
        pe_idx  = '0;
        pe_data = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pe_mask[i]) begin
                pe_any  = 1'b1;
                pe_idx  = IDXW'(i);
                pe_data = pe_vec[i*DW +: DW];
            end
        end
        pe_rest = pe_mask & ~(LANES'(1) << pe_idx);
    end

    // Next-state and next-output logic for the IDLE/STREAM controller.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d = vec_in;
                    if (pe_any) begin
                        state_d = STREAM;
                        valid_d = 1'b1;
                        data_d  = pe_data;
                        idx_d   = pe_idx;
                        last_d  = (pe_rest == '0);
                        rem_d   = pe_rest;
                    end else begin
                        // Empty mask: nothing to send, report completion directly.
                        rem_d  = '0;
                        done_d = 1'b1;
                    end
                end
            end

            STREAM: begin
                if (valid_q && out_if.out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        data_d  = '0;
                        idx_d   = '0;
                        last_d  = 1'b0;
                        rem_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        // Next higher enabled lane goes out on the very next cycle.
                        data_d = pe_data;
                        idx_d  = pe_idx;
                        last_d = (pe_rest == '0);
                        rem_d  = pe_rest;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, captured vector and registered outputs; reset aborts any stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign busy             = (state_q == STREAM);
    assign done             = done_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_idx   = idx_q;
    assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_vector_lane_serializer.sv
// tb/tb_vector_lane_serializer.sv - directed self-checking bench for vector_lane_serializer
module tb_vector_lane_serializer;

    localparam int LANES = 16;
    localparam int DW    = 32;
    localparam int IDXW  = 4;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [LANES*DW-1:0] vec_in;
    logic [LANES-1:0]    lane_mask;
    logic                busy;
    logic                done;

    int n_asrt = 0;
    int n_fail = 0;

    vector_lane_serializer_if #(.DW(DW), .IDXW(IDXW)) vif ();

    vector_lane_serializer #(.LANES(LANES), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vec_in    (vec_in),
`ifdef VSER_MASK_EN
        .lane_mask (lane_mask),
`endif
        .busy      (busy),
        .done      (done),
        .out_if    (vif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*DW-1:0] build(input logic [31:0] base);
        logic [LANES*DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = base + 32'(i);
        return v;
    endfunction

    initial begin
        int e;
        int cyc;
        logic hs;
        int exp_idx [4];

        rst_n         = 1'b0;
        start         = 1'b0;
        vec_in        = '0;
        lane_mask     = '1;
        vif.out_ready = 1'b0;
        #1;
        chk("rst_valid", vif.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", vif.out_data, 0);
        chk("rst_idx", vif.out_idx, 0);
        chk("rst_last", vif.out_last, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_valid", vif.out_valid, 0);

        // Full stream with ready held high.
        vec_in        = build(32'hA000_0000);
        vif.out_ready = 1'b1;
        start         = 1'b1;
        step();
        start = 1'b0;
        chk("full_busy", busy, 1);
        for (int k = 0; k < LANES; k++) begin
            chk("full_valid", vif.out_valid, 1);
            chk("full_idx", vif.out_idx, k);
            chk("full_data", vif.out_data, 32'hA000_0000 + k);
            chk("full_last", vif.out_last, (k == LANES - 1));
            chk("full_done_low", done, 0);
            step();
        end
        chk("full_end_valid", vif.out_valid, 0);
        chk("full_end_busy", busy, 0);
        chk("full_end_done", done, 1);
        step();
        chk("full_done_pulse", done, 0);

        // Backpressure: ready pattern 1,0,0 repeating.
        vec_in = build(32'hA000_0000);
        start  = 1'b1;
        step();
        start = 1'b0;
        e   = 0;
        cyc = 0;
        while (e < LANES && cyc < 200) begin
            vif.out_ready = (cyc % 3 == 0);
            chk("bp_valid", vif.out_valid, 1);
            chk("bp_idx", vif.out_idx, e);
            chk("bp_data", vif.out_data, 32'hA000_0000 + e);
            chk("bp_last", vif.out_last, (e == LANES - 1));
            hs = vif.out_ready;
            step();
            if (hs) e++;
            cyc++;
        end
        chk("bp_handshakes", e, LANES);
        chk("bp_done", done, 1);
        chk("bp_end_valid", vif.out_valid, 0);
        vif.out_ready = 1'b1;
        step();

        // start while busy is ignored; start in the done cycle is accepted.
        vec_in = build(32'hA000_0000);
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            chk("ign_idx", vif.out_idx, k);
            chk("ign_data", vif.out_data, 32'hA000_0000 + k);
            if (k == 3) begin
                start  = 1'b1;
                vec_in = build(32'hB000_0000);
            end else begin
                start = 1'b0;
            end
            step();
        end
        chk("ign_done", done, 1);
        chk("ign_end_valid", vif.out_valid, 0);
        start  = 1'b1;
        vec_in = build(32'hC000_0000);
        step();
        start = 1'b0;
        chk("redo_valid", vif.out_valid, 1);
        chk("redo_idx", vif.out_idx, 0);
        chk("redo_data", vif.out_data, 32'hC000_0000);
        chk("redo_done", done, 0);
        chk("redo_busy", busy, 1);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("redo_beat_idx", vif.out_idx, k);
            chk("redo_beat_data", vif.out_data, 32'hC000_0000 + k);
        end

        // Asynchronous reset at beat 7.
        rst_n = 1'b0;
        #1;
        chk("arst_valid", vif.out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_data", vif.out_data, 0);
        chk("arst_idx", vif.out_idx, 0);
        chk("arst_last", vif.out_last, 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_rst_valid", vif.out_valid, 0);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end

`ifdef VSER_MASK_EN
        // Sparse mask: lanes 0,5,10,15 back-to-back.
        exp_idx   = '{0, 5, 10, 15};
        lane_mask = 16'h8421;
        vec_in    = build(32'hA000_0000);
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("mask_valid", vif.out_valid, 1);
            chk("mask_idx", vif.out_idx, exp_idx[j]);
            chk("mask_data", vif.out_data, 32'hA000_0000 + exp_idx[j]);
            chk("mask_last", vif.out_last, (j == 3));
            step();
        end
        chk("mask_done", done, 1);
        chk("mask_end_valid", vif.out_valid, 0);
        step();

        // Empty mask: done pulse only.
        lane_mask = 16'h0000;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("empty_valid", vif.out_valid, 0);
        chk("empty_busy", busy, 0);
        chk("empty_done", done, 1);
        step();
        chk("empty_done_pulse", done, 0);
        chk("empty_valid2", vif.out_valid, 0);
        lane_mask = '1;
`else
        exp_idx = '{0, 0, 0, 0};
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
